spi_slave_cmd_ctrl: RTL

SPI_SLAVE_CMD_CTRL -- requirements
Module: spi_slave_cmd_ctrl

---
 rtl/spi_slave_cmd_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_cmd_ctrl.sv
// SPI slave command controller: decodes a command byte, performs one
// register write or streams register read data after a dummy period.
// Rx logic runs on rising sclk, tx logic on falling sclk; csn high clears
// all transaction state asynchronously.
`timescale 1ns/1ps
module spi_slave_cmd_ctrl #(
   parameter int REG_SIZE = 8
) (
   input  logic                sclk,
   input  logic                rstn,
   input  logic                csn,
   input  logic [3:0]          sdi,
   output logic [3:0]          sdo,
   output logic                sdo_oe,
   input  logic                en_qpi,
   input  logic [7:0]          dummy_cycles,
   output logic [REG_SIZE-1:0] reg_wr_data,
   output logic [1:0]          reg_wr_addr,
   output logic                reg_wr_valid,
   output logic [1:0]          reg_rd_addr,
   input  logic [REG_SIZE-1:0] reg_rd_data
);

   localparam int CW = $clog2(REG_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE, CMD, WR_DATA, RD_DUMMY, RD_DATA, IGNORE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [REG_SIZE-1:0] rx_sr_q, rx_sr_d;
   logic [7:0]          dummy_q, dummy_d;
   logic [1:0]          addr_q, addr_d;
   logic [REG_SIZE-1:0] tx_sr_q, tx_sr_d;
   logic [CW-1:0]       tx_cnt_q, tx_cnt_d;

   logic [CW-1:0]       sym_per_byte;
   logic                byte_last;
   logic [REG_SIZE-1:0] rx_nxt;
   logic [7:0]          cmd;
   logic                cmd_wr, cmd_rd;

   // Symbols per byte and the shift-in value including the bits on sdi now.
   always_comb begin
      sym_per_byte = en_qpi ? CW'(REG_SIZE / 4) : CW'(REG_SIZE);
      byte_last    = (bit_cnt_q == sym_per_byte - CW'(1));
      rx_nxt       = en_qpi ? {rx_sr_q[REG_SIZE-5:0], sdi}
                            : {rx_sr_q[REG_SIZE-2:0], sdi[0]};
      cmd          = rx_nxt[7:0];
      cmd_wr       = (cmd[7:6] == 2'b00) && (cmd[3:0] == 4'h1);
      cmd_rd       = (cmd[7:6] == 2'b00) && (cmd[3:0] == 4'h5);
   end

   // Rx next-state: byte assembly, command decode and dummy countdown.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = byte_last ? '0 : bit_cnt_q + CW'(1);
      rx_sr_d   = rx_nxt;
      dummy_d   = dummy_q;
      addr_d    = addr_q;
      case (state_q)
         IDLE, CMD: begin
            state_d = CMD;
            if (byte_last) begin
               addr_d  = cmd[5:4];
               dummy_d = dummy_cycles;
               if (cmd_wr)
                  state_d = WR_DATA;
               else if (cmd_rd)
                  state_d = (dummy_cycles == 8'd0) ? RD_DATA : RD_DUMMY;
               else
                  state_d = IGNORE;
            end
         end
         WR_DATA: begin
            // Only one write per transaction; the rest of the burst is dropped.
            if (byte_last)
               state_d = IGNORE;
         end
         RD_DUMMY: begin
            dummy_d = dummy_q - 8'd1;
            if (dummy_q <= 8'd1)
               state_d = RD_DATA;
         end
         RD_DATA, IGNORE: state_d = state_q;
         default:         state_d = IGNORE;
      endcase
   end

   // Rx registers; csn high aborts the transaction like a reset.
   always_ff @(posedge sclk or negedge rstn or posedge csn) begin
      if (!rstn || csn) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         rx_sr_q   <= '0;
         dummy_q   <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sr_q   <= rx_sr_d;
         dummy_q   <= dummy_d;
         addr_q    <= addr_d;
      end
   end

   // Zero-latency write strobe: the register file captures on the same edge
   // that delivers the last data bits, so data includes the live sdi bits.
   always_comb begin
      reg_wr_valid = rstn && !csn && (state_q == WR_DATA) && byte_last;
      reg_wr_data  = reg_wr_valid ? rx_nxt : '0;
      reg_wr_addr  = reg_wr_valid ? addr_q : '0;
      reg_rd_addr  = addr_q;
   end

   // Tx next-state: reload from the register at each byte boundary, else shift.
   always_comb begin
      tx_sr_d  = tx_sr_q;
      tx_cnt_d = tx_cnt_q;
      if (state_q == RD_DATA) begin
         if ((tx_cnt_q == '0) || (tx_cnt_q == sym_per_byte)) begin
            tx_sr_d  = reg_rd_data;
            tx_cnt_d = CW'(1);
         end else begin
            tx_sr_d  = en_qpi ? {tx_sr_q[REG_SIZE-5:0], 4'b0000}
                              : {tx_sr_q[REG_SIZE-2:0], 1'b0};
            tx_cnt_d = tx_cnt_q + CW'(1);
         end
      end
   end

   // Tx registers update on the falling edge so data is stable for the master.
   always_ff @(negedge sclk or negedge rstn or posedge csn) begin
      if (!rstn || csn) begin
         tx_sr_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         tx_sr_q  <= tx_sr_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   // Output drive: sdo is forced low whenever the output is not enabled.
   always_comb begin
      sdo_oe = (state_q == RD_DATA);
      sdo    = 4'b0000;
      if (sdo_oe)
         sdo = en_qpi ? tx_sr_q[REG_SIZE-1 -: 4] : {3'b000, tx_sr_q[REG_SIZE-1]};
   end

endmodule
